// File: rtl/qreg_param.sv
// rtl/qreg_param.sv - parametrised multiplier Q register with shift counter
//
// Optional feature macro: QREG_ROTATE_EN (code 101 rotates right when defined,
// otherwise code 101 behaves as Hold).
//
// Ports:
//   clock        rising-edge clock
//   reset        asynchronous active-high reset
//   control[2:0] operation select
//                000 Load, 001 Clear, 010 ShiftR, 011 Hold,
//                100 ShiftL, 101 Rotate/Hold, 110 ArithR, 111 Hold
//   load         parallel load data
//   A_in         serial in at the MSB on right shift
//   S_in         serial in at the LSB on left shift
//   Q_out        registered contents
//   Q_lsb        Q_out[0]
//   Q_msb        Q_out[WIDTH-1]
//   shift_count  shifts since last Load/Clear, saturates at WIDTH
//   done         shift_count == WIDTH

module qreg_param #(
    parameter int               WIDTH       = 8,
    parameter int               CNT_W       = $clog2(WIDTH + 1),
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [2:0]       control,
    input  logic [WIDTH-1:0] load,
    input  logic             A_in,
    input  logic             S_in,
    output logic [WIDTH-1:0] Q_out,
    output logic             Q_lsb,
    output logic             Q_msb,
    output logic [CNT_W-1:0] shift_count,
    output logic             done
);

    localparam logic [2:0] OP_LOAD   = 3'b000;
    localparam logic [2:0] OP_CLEAR  = 3'b001;
    localparam logic [2:0] OP_SHIFTR = 3'b010;
    localparam logic [2:0] OP_SHIFTL = 3'b100;
`ifdef QREG_ROTATE_EN
    localparam logic [2:0] OP_ROTATE = 3'b101;
`endif
    localparam logic [2:0] OP_ARITHR = 3'b110;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

    // Saturating increment: once WIDTH shifts have happened the sequencer
    // sees a stable done, even if it keeps shifting.
    logic [CNT_W-1:0] count_next;
    always_comb begin
        count_next = shift_count;
        if (shift_count < CNT_MAX) begin
            count_next = shift_count + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            Q_out       <= RESET_VALUE;
            shift_count <= '0;
        end else begin
            case (control)
                OP_LOAD: begin
                    Q_out       <= load;
                    shift_count <= '0;
                end
                OP_CLEAR: begin
                    Q_out       <= RESET_VALUE;
                    shift_count <= '0;
                end
                OP_SHIFTR: begin
                    Q_out       <= {A_in, Q_out[WIDTH-1:1]};
                    shift_count <= count_next;
                end
                OP_SHIFTL: begin
                    Q_out       <= {Q_out[WIDTH-2:0], S_in};
                    shift_count <= count_next;
                end
`ifdef QREG_ROTATE_EN
                OP_ROTATE: begin
                    Q_out       <= {Q_out[0], Q_out[WIDTH-1:1]};
                    shift_count <= count_next;
                end
`endif
                OP_ARITHR: begin
                    Q_out       <= {Q_out[WIDTH-1], Q_out[WIDTH-1:1]};
                    shift_count <= count_next;
                end
                default: begin
                    // Hold and reserved codes leave both registers untouched.
                end
            endcase
        end
    end

    assign Q_lsb = Q_out[0];
    assign Q_msb = Q_out[WIDTH-1];
    assign done  = (shift_count == CNT_MAX);

endmodule
